// File: rtl/bcd_8421_to_bin.sv
// Iterative packed 8421-BCD to binary converter: acc = acc*10 + digit, MS digit first, one digit per clock.
// Optional feature macro BCD_DIGIT_CHECK_EN: flag digits > 9 through err and force data_out to 0.
module bcd_8421_to_bin #(
    parameter int DIG_NUM = 6,
    parameter int DATA_W  = 20
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic [4*DIG_NUM-1:0]   bcd_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_W-1:0]      data_out,
    output logic                   out_valid,
    output logic                   err
);

    typedef enum logic {IDLE, CONV} state_t;

    localparam int CNT_W = (DIG_NUM > 1) ? $clog2(DIG_NUM) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIG_NUM - 1);

    state_t               state;
    logic [4*DIG_NUM-1:0] shift_reg;
    logic [DATA_W-1:0]    acc;
    logic [DATA_W-1:0]    acc_next;
    logic [CNT_W-1:0]     cnt;
    logic [3:0]           top_digit;

    assign top_digit = shift_reg[4*DIG_NUM-1 -: 4];

    // The x10 product is reduced mod 2^DATA_W, which matches computing it wider
    // and then keeping only the low DATA_W bits.
    assign acc_next = (acc << 3) + (acc << 1) + DATA_W'(top_digit);

`ifdef BCD_DIGIT_CHECK_EN
    logic err_sticky;
    logic bad_digit;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIG_NUM; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            data_out  <= '0;
            out_valid <= 1'b0;
            shift_reg <= '0;
            acc       <= '0;
            cnt       <= '0;
`ifdef BCD_DIGIT_CHECK_EN
            err        <= 1'b0;
            err_sticky <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_reg <= bcd_in;
                        acc       <= '0;
                        cnt       <= '0;
                        in_ready  <= 1'b0;
                        state     <= CONV;
`ifdef BCD_DIGIT_CHECK_EN
                        err_sticky <= bad_digit;
                        err        <= 1'b0;
`endif
                    end
                end
                CONV: begin
                    acc       <= acc_next;
                    shift_reg <= shift_reg << 4;
                    cnt       <= cnt + 1'b1;
                    // Last digit: publish the result and become ready in the same cycle
                    if (cnt == LAST_CNT) begin
`ifdef BCD_DIGIT_CHECK_EN
                        data_out <= err_sticky ? '0 : acc_next;
                        err      <= err_sticky;
`else
                        data_out <= acc_next;
`endif
                        out_valid <= 1'b1;
                        in_ready  <= 1'b1;
                        cnt       <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_8421_to_bin.sv
// Self-checking bench for bcd_8421_to_bin: directed cases plus randomized conversions
// compared against a positional-weight decimal model.
module tb_bcd_8421_to_bin;

    localparam int DIG_NUM = 6;
    localparam int DATA_W  = 20;

    logic                 sys_clk;
    logic                 sys_rst;
    logic [4*DIG_NUM-1:0] bcd_in;
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_W-1:0]    data_out;
    logic                 out_valid;
    logic                 err;

    int check_count;
    int error_count;

    bcd_8421_to_bin #(.DIG_NUM(DIG_NUM), .DATA_W(DATA_W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .bcd_in    (bcd_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .err       (err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Reference: sum of digit * 10^position, reduced to DATA_W bits
    function automatic logic [DATA_W-1:0] ref_data(input logic [4*DIG_NUM-1:0] bcd);
        longint unsigned total;
        longint unsigned weight;
        total  = 0;
        weight = 1;
        for (int i = 0; i < DIG_NUM; i++) begin
            total  = total + longint'(bcd[4*i +: 4]) * weight;
            weight = weight * 10;
        end
`ifdef BCD_DIGIT_CHECK_EN
        if (ref_err(bcd)) return '0;
`endif
        return total[DATA_W-1:0];
    endfunction

    function automatic logic ref_err(input logic [4*DIG_NUM-1:0] bcd);
`ifdef BCD_DIGIT_CHECK_EN
        for (int i = 0; i < DIG_NUM; i++) begin
            if (bcd[4*i +: 4] > 4'd9) return 1'b1;
        end
`endif
        return (bcd === 'x);
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Drive one conversion and check the full handshake timeline.
    // hold_valid keeps in_valid high through busy and into the result cycle.
    // scramble changes bcd_in while the conversion runs.
    task automatic apply_stimulus(input logic [4*DIG_NUM-1:0] bcd, input bit hold_valid, input bit scramble);
        logic [DATA_W-1:0] exp_data;
        exp_data = ref_data(bcd);
        bcd_in   = bcd;
        in_valid = 1'b1;
        check_output("ready_before_accept", 32'(in_ready), 32'd1);
        tick();
        if (!hold_valid) in_valid = 1'b0;
        for (int c = 1; c <= DIG_NUM; c++) begin
            check_output("busy_ready", 32'(in_ready), 32'd0);
            check_output("busy_strobe", 32'(out_valid), 32'd0);
            if (scramble) bcd_in = 24'($urandom);
            tick();
        end
        check_output("result_strobe", 32'(out_valid), 32'd1);
        check_output("result_ready", 32'(in_ready), 32'd1);
        check_output("result_data", 32'(data_out), 32'(exp_data));
        check_output("result_err", 32'(err), 32'(ref_err(bcd)));
        if (!hold_valid) begin
            tick();
            check_output("strobe_single", 32'(out_valid), 32'd0);
            check_output("data_held", 32'(data_out), 32'(exp_data));
        end
    endtask

    initial begin
        logic [4*DIG_NUM-1:0] rand_bcd;
        logic [3:0]           nib;
        check_count = 0;
        error_count = 0;
        sys_rst  = 1'b1;
        in_valid = 1'b1;
        bcd_in   = 24'h111111;

        // Reset held with in_valid asserted: block stays idle
        for (int c = 0; c < 3; c++) begin
            tick();
            check_output("rst_ready", 32'(in_ready), 32'd1);
            check_output("rst_strobe", 32'(out_valid), 32'd0);
            check_output("rst_data", 32'(data_out), 32'd0);
            check_output("rst_err", 32'(err), 32'd0);
        end
        sys_rst  = 1'b0;
        in_valid = 1'b0;
        tick();

        apply_stimulus(24'h123456, 1'b0, 1'b0);

        // Back-to-back with in_valid held high
        apply_stimulus(24'h999999, 1'b1, 1'b0);
        apply_stimulus(24'h000000, 1'b0, 1'b0);

        // Reset in the middle of a conversion discards it
        bcd_in   = 24'h654321;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2;
        sys_rst = 1'b1;
        #1;
        check_output("midrst_ready", 32'(in_ready), 32'd1);
        check_output("midrst_strobe", 32'(out_valid), 32'd0);
        check_output("midrst_data", 32'(data_out), 32'd0);
        #2;
        sys_rst = 1'b0;
        for (int c = 0; c < DIG_NUM + 2; c++) begin
            tick();
            check_output("midrst_no_strobe", 32'(out_valid), 32'd0);
        end
        apply_stimulus(24'h987654, 1'b0, 1'b0);

        // Non-decimal digit
        apply_stimulus(24'h12A456, 1'b0, 1'b0);

        // Input changes during conversion must not matter
        apply_stimulus(24'h000001, 1'b0, 1'b1);

        // Randomized conversions, occasionally with non-decimal nibbles
        for (int n = 0; n < 25; n++) begin
            for (int d = 0; d < DIG_NUM; d++) begin
                nib = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
                rand_bcd[4*d +: 4] = nib;
            end
            apply_stimulus(rand_bcd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;
        tick();
        check_output("final_idle_strobe", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
